wts_channel_mixer: RTL and testbench
====================================

# wts_channel_mixer

Time-multiplexed output mixer for the wave table sound core. It sits directly downstream of the 4-channel noise generator and the wave-memory read. Each slot cycle it takes the current channel's signed wave sample, gates it with that slot's noise bits, scales it by the channel volume and accumulates it. Once per frame (slot 5, the CPU slot) it emits one saturated mixed sample to the DAC stage.

## Interface

Parameters: none.

Ports:
- `clk` in, 1: system clock; sole clock.
- `nreset` in, 1: reset, synchronous, active-low (sampled on rising `clk`).
- `active` in, 3: slot index. 0..4 is channel A..E; 5 is the CPU/flush slot; 6 and 7 are no-op.
- `noise0` in, 1: noise gate 0 for the current slot (1 = pass).
- `noise1` in, 1: noise gate 1 for the current slot (1 = pass).
- `wave_sample` in, 8: signed two's-complement sample of the current slot's channel.
- `reg_volume_a` .. `reg_volume_e` in, 4 each: unsigned volume 0..15 per channel (0 = mute).
- `mixed_out` out, 12: signed mixed sample; holds between updates.
- `mixed_valid` out, 1: one-cycle pulse when `mixed_out` updates.

## Operation

Stage 1 (registered each `clk`):
- If `active` is 0..4:
  - Select the volume by `active`.
  - gate = `noise0 & noise1`.
  - s = gate ? `wave_sample` : 0.
  - p <= s × vol (signed 8 × unsigned 4 gives signed 12; range −1920..+1905).
  - p_valid <= 1, p_flush <= 0.
- If `active` == 5: p_valid <= 0, p_flush <= 1.
- If `active` is 6 or 7: p_valid <= 0, p_flush <= 0 (no-op; accumulator untouched).

Stage 2 (registered):
- If p_valid: acc <= acc + sign-extended p. `acc` is 15-bit signed and saturates at +16383 / −16384; it never wraps.
- If p_flush:
  - `mixed_out` <= sat12(acc >>> 2), using an arithmetic shift. sat12 clamps to +2047 / −2048.
  - acc <= 0.
  - `mixed_valid` <= 1.
- Otherwise: `mixed_valid` <= 0.
- p_valid and p_flush are mutually exclusive by construction. No priority logic is needed.

Boundary rules:
- More than five channel slots without a flush: accumulation continues and saturates at the 15-bit limits.
- Flush with no preceding channel slots: outputs sat12(0 >>> 2) = 0 and pulses `mixed_valid`.
- Repeated slot 5 (two flushes in a row): the second flush outputs 0 with a valid pulse.
- Volume and sample are sampled only in their own slot cycle. Register writes take effect on the next matching slot.

Reset (`nreset` low at a rising edge):
- p, p_valid, p_flush, acc <= 0.
- `mixed_out` <= 0, `mixed_valid` <= 0.
- A partial frame in progress is discarded. The first output after release reflects only slots seen after release.

## Timing

- Slot sampled at edge N. Its product is in p after N and is accumulated at edge N+1.
- `active` == 5 sampled at edge N: p_flush is set after N. `mixed_out` and `mixed_valid` update at edge N+1, and `mixed_valid` is high for exactly one cycle.
- A channel slot at edge N−1 (the slot-4 position) is included in the flush result at N+1.
- A slot 0 sampled at edge N+1 (the next frame) accumulates into the freshly cleared acc at N+2.
- Latency from the flush slot to output: 1 cycle after the sampling edge, i.e. 2 edges from the `active` == 5 presentation.
- Throughput: one slot per clock. There is no back-pressure.

## Configuration

- `WTS_MIXER_NOISE_EN`
  - Defined: noise gating as above (gate = `noise0 & noise1`).
  - Undefined: `noise0`/`noise1` are ignored, gate is constant 1, and no gating logic is synthesized. Ports remain present.

## Test plan

- Reset: hold `nreset` low 3 clk with random inputs -> `mixed_out` = 0, `mixed_valid` = 0 throughout, and 1 cycle after release.
- Nominal frame: slots 0..4 with `wave_sample` = +100, all volumes 15, noise = 1, then slot 5 -> sum 7500, `mixed_out` = 1875. `mixed_valid` pulses once, at edge N+1 after the slot-5 edge N.
- Saturation: all samples +127, volume 15 -> 9525 >>> 2 = 2381, clamped to `mixed_out` = 2047. All samples −128 -> −2400, clamped to −2048.
- Noise gate: the nominal frame with `noise0` = 0 during slot 1 -> 6000 >>> 2 = 1500 with the macro defined, and 1875 with it undefined.
- Arithmetic/no-op: slot 0 `wave_sample` = −1, volume 1, other volumes 0, slots 6 and 7 inserted between slots 2 and 3 -> `mixed_out` = −1 (arithmetic floor). The inserted slots do not change the result.
- Reset mid-frame: assert reset after slot 2, release, run one full nominal frame -> `mixed_out` = 1875 (no carry-over). No `mixed_valid` pulse occurs before that frame's flush.

Source files
------------

// File: rtl/wts_channel_mixer.sv
// wts_channel_mixer: time-multiplexed 5-channel volume/noise mixer with a saturating 15-bit accumulator.
// Optional feature macro WTS_MIXER_NOISE_EN: when defined, each slot's sample is gated by noise0 & noise1.
module wts_channel_mixer (
    input  logic        clk,
    input  logic        nreset,
    input  logic [2:0]  active,
    input  logic        noise0,
    input  logic        noise1,
    input  logic [7:0]  wave_sample,
    input  logic [3:0]  reg_volume_a,
    input  logic [3:0]  reg_volume_b,
    input  logic [3:0]  reg_volume_c,
    input  logic [3:0]  reg_volume_d,
    input  logic [3:0]  reg_volume_e,
    output logic [11:0] mixed_out,
    output logic        mixed_valid
);

    typedef struct packed {
        logic signed [11:0] p;
        logic               valid;
        logic               flush;
    } prod_t;

    localparam logic signed [15:0] ACC_MAX = 16'sd16383;
    localparam logic signed [15:0] ACC_MIN = -16'sd16384;
    localparam logic signed [12:0] OUT_MAX = 13'sd2047;
    localparam logic signed [12:0] OUT_MIN = -13'sd2048;

    prod_t              stage1, stage1_next;
    logic [3:0]         vol_sel;
    logic               gate;
    logic signed [11:0] s_ext;
    logic signed [11:0] vol_ext;

    logic signed [14:0] acc;
    logic signed [15:0] acc_sum;
    logic signed [14:0] acc_sat;
    logic signed [12:0] acc_shr;
    logic signed [11:0] flush_val;

    always_comb begin
        vol_sel = 4'd0;
        case (active)
            3'd0:    vol_sel = reg_volume_a;
            3'd1:    vol_sel = reg_volume_b;
            3'd2:    vol_sel = reg_volume_c;
            3'd3:    vol_sel = reg_volume_d;
            3'd4:    vol_sel = reg_volume_e;
            default: vol_sel = 4'd0;
        endcase
    end

`ifdef WTS_MIXER_NOISE_EN
    assign gate = noise0 & noise1;
`else
    logic unused_noise;
    assign unused_noise = noise0 ^ noise1;
    assign gate = 1'b1;
`endif

    // 12-bit product is exact: |s * vol| <= 128 * 15 fits in signed 12 bits.
    always_comb begin
        stage1_next = '0;
        s_ext       = gate ? {{4{wave_sample[7]}}, wave_sample} : 12'sd0;
        vol_ext     = {8'd0, vol_sel};
        if (active <= 3'd4) begin
            stage1_next.p     = s_ext * vol_ext;
            stage1_next.valid = 1'b1;
        end else if (active == 3'd5) begin
            stage1_next.flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) stage1 <= '0;
        else         stage1 <= stage1_next;
    end

    always_comb begin
        acc_sum = {acc[14], acc} + {{4{stage1.p[11]}}, stage1.p};
        if (acc_sum > ACC_MAX)      acc_sat = ACC_MAX[14:0];
        else if (acc_sum < ACC_MIN) acc_sat = ACC_MIN[14:0];
        else                        acc_sat = acc_sum[14:0];
    end

    // Dropping the two LSBs of the signed accumulator is the arithmetic shift (floor).
    always_comb begin
        acc_shr = acc[14:2];
        if (acc_shr > OUT_MAX)      flush_val = OUT_MAX[11:0];
        else if (acc_shr < OUT_MIN) flush_val = OUT_MIN[11:0];
        else                        flush_val = acc_shr[11:0];
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            acc         <= '0;
            mixed_out   <= '0;
            mixed_valid <= 1'b0;
        end else begin
            mixed_valid <= 1'b0;
            if (stage1.valid) acc <= acc_sat;
            if (stage1.flush) begin
                mixed_out   <= flush_val;
                acc         <= '0;
                mixed_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wts_channel_mixer.sv
// Bench for wts_channel_mixer: per-cycle compare against an integer frame model plus literal frame results.
module tb_wts_channel_mixer;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [2:0]  active = 3'd7;
    logic        noise0 = 1'b1;
    logic        noise1 = 1'b1;
    logic [7:0]  wave_sample = 8'd0;
    logic [3:0]  vol_a = 4'd15, vol_b = 4'd15, vol_c = 4'd15, vol_d = 4'd15, vol_e = 4'd15;
    logic [11:0] mixed_out;
    logic        mixed_valid;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b1;

    always #5 clk = ~clk;

    wts_channel_mixer dut (
        .clk          (clk),
        .nreset       (nreset),
        .active       (active),
        .noise0       (noise0),
        .noise1       (noise1),
        .wave_sample  (wave_sample),
        .reg_volume_a (vol_a),
        .reg_volume_b (vol_b),
        .reg_volume_c (vol_c),
        .reg_volume_d (vol_d),
        .reg_volume_e (vol_e),
        .mixed_out    (mixed_out),
        .mixed_valid  (mixed_valid)
    );

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int floor4(input int a);
        if (a >= 0) return a / 4;
        return -((-a + 3) / 4);
    endfunction

    function automatic int vol_of(input int ch);
        case (ch)
            0: return int'(vol_a);
            1: return int'(vol_b);
            2: return int'(vol_c);
            3: return int'(vol_d);
            default: return int'(vol_e);
        endcase
    endfunction

    // Model: what was seen last edge (a product or a flush) is applied at this edge.
    int m_kind = 0;
    int m_p = 0;
    int m_acc = 0;
    int m_out = 0;
    int m_vld = 0;

    always @(posedge clk) begin
        int g;
        if (!nreset) begin
            m_kind = 0; m_p = 0; m_acc = 0; m_out = 0; m_vld = 0;
        end else begin
            m_vld = 0;
            if (m_kind == 1) begin
                m_acc = clampi(m_acc + m_p, -16384, 16383);
            end else if (m_kind == 2) begin
                m_out = clampi(floor4(m_acc), -2048, 2047);
                m_acc = 0;
                m_vld = 1;
            end
            m_kind = 0;
            m_p    = 0;
            if (active <= 3'd4) begin
`ifdef WTS_MIXER_NOISE_EN
                g = (noise0 && noise1) ? 1 : 0;
`else
                g = 1;
`endif
                m_kind = 1;
                m_p    = g * int'($signed(wave_sample)) * vol_of(int'(active));
            end else if (active == 3'd5) begin
                m_kind = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (mixed_valid !== (m_vld != 0) || int'($signed(mixed_out)) != m_out) begin
                errors++;
                $display("FAIL model t=%0t: got out=%0d valid=%b, expected out=%0d valid=%0d",
                         $time, $signed(mixed_out), mixed_valid, m_out, m_vld);
            end
        end
    end

    task automatic step(input logic [2:0] a, input logic [7:0] s, input logic n0, input logic n1);
        active = a; wave_sample = s; noise0 = n0; noise1 = n1;
        @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] s);
        for (int ch = 0; ch < 5; ch++) step(3'(ch), s, 1'b1, 1'b1);
    endtask

    task automatic check_lit(input string name, input logic exp_v, input int exp_out);
        checks++;
        if (mixed_valid !== exp_v || int'($signed(mixed_out)) != exp_out) begin
            errors++;
            $display("FAIL %s: got out=%0d valid=%b, expected out=%0d valid=%b",
                     name, $signed(mixed_out), mixed_valid, exp_out, exp_v);
        end
    endtask

    // Flush presented at edge N, result visible after edge N+1.
    task automatic flush_check(input string name, input int exp_out);
        step(3'd5, 8'($urandom), 1'b1, 1'b1);
        check_lit({name, "_early"}, 1'b0, exp_out == 0 ? 0 : int'($signed(mixed_out)));
        step(3'd7, 8'($urandom), 1'b1, 1'b1);
        check_lit(name, 1'b1, exp_out);
    endtask

    initial begin
        // Reset held with random inputs
        nreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            check_lit("reset_hold", 1'b0, 0);
        end
        nreset = 1'b1;
        step(3'd7, 8'd0, 1'b1, 1'b1);
        check_lit("reset_release", 1'b0, 0);

        frame(8'd100);
        flush_check("nominal", 1875);

        frame(8'h7F);
        flush_check("sat_pos", 2047);
        frame(8'h80);
        flush_check("sat_neg", -2048);

        step(3'd0, 8'd100, 1'b1, 1'b1);
        step(3'd1, 8'd100, 1'b0, 1'b1);
        for (int ch = 2; ch < 5; ch++) step(3'(ch), 8'd100, 1'b1, 1'b1);
`ifdef WTS_MIXER_NOISE_EN
        flush_check("noise_gate", 1500);
`else
        flush_check("noise_gate", 1875);
`endif

        vol_a = 4'd1; vol_b = 4'd0; vol_c = 4'd0; vol_d = 4'd0; vol_e = 4'd0;
        step(3'd0, 8'hFF, 1'b1, 1'b1);
        step(3'd1, 8'($urandom), 1'b1, 1'b1);
        step(3'd2, 8'($urandom), 1'b1, 1'b1);
        step(3'd6, 8'($urandom), 1'b1, 1'b1);
        step(3'd7, 8'($urandom), 1'b1, 1'b1);
        step(3'd3, 8'($urandom), 1'b1, 1'b1);
        step(3'd4, 8'($urandom), 1'b1, 1'b1);
        flush_check("arith_floor", -1);
        vol_a = 4'd15; vol_b = 4'd15; vol_c = 4'd15; vol_d = 4'd15; vol_e = 4'd15;

        // Back-to-back flushes: second one sees a cleared accumulator
        frame(8'd100);
        step(3'd5, 8'd0, 1'b1, 1'b1);
        step(3'd5, 8'd0, 1'b1, 1'b1);
        check_lit("double_flush_1", 1'b1, 1875);
        step(3'd7, 8'd0, 1'b1, 1'b1);
        check_lit("double_flush_2", 1'b1, 0);
        step(3'd7, 8'd0, 1'b1, 1'b1);
        check_lit("valid_one_cycle", 1'b0, 0);

        // Saturate high, then pull back down: a wrapped accumulator gives 1886 instead
        for (int i = 0; i < 9; i++) step(3'(i % 5), 8'h7F, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(3'(i), 8'h80, 1'b1, 1'b1);
        flush_check("acc_saturate", 1695);

        step(3'd0, 8'd100, 1'b1, 1'b1);
        step(3'd1, 8'd100, 1'b1, 1'b1);
        step(3'd2, 8'd100, 1'b1, 1'b1);
        nreset = 1'b0;
        step(3'd7, 8'd0, 1'b1, 1'b1);
        step(3'd7, 8'd0, 1'b1, 1'b1);
        nreset = 1'b1;
        frame(8'd100);
        flush_check("reset_midframe", 1875);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0: vol_a = 4'($urandom);
                    1: vol_b = 4'($urandom);
                    2: vol_c = 4'($urandom);
                    3: vol_d = 4'($urandom);
                    default: vol_e = 4'($urandom);
                endcase
            end
            nreset = ($urandom_range(0, 99) != 0);
            step(3'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end
        nreset = 1'b1;
        step(3'd7, 8'd0, 1'b1, 1'b1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
